button_debounce: RTL and testbench

- Multi-channel push-button conditioner directly upstream of the one-pulse stage.
- Synchronises raw board buttons into the clk domain, rejects contact bounce with a per-channel stability counter, and drives a clean level output per channel.
- Each output feeds the one-pulse stage's debounced-push input.

---
 rtl/button_debounce_pkg.sv | 27 ++
 rtl/debounce_chan.sv | 140 ++++++++++++++
 rtl/button_debounce.sv | 34 +++
 tb/tb_button_debounce.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// Shared types, 100 MHz default timing constants and width helper for the
// button debouncer.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } deb_state_e;

  localparam int DEF_STABLE_CYCLES = 32'd1000000;
  localparam int DEF_LONG_CYCLES   = 32'd100000000;

  // Smallest width w with 2**w > cycles.
  function automatic int min_cnt_w(input int cycles);
    int w;
    w = $clog2(cycles + 32'd1);
    if (w < 32'd1) begin
      w = 32'd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, qualification FSM and counter.
// The long-press hold counter exists only with BUTTON_DEBOUNCE_LONGPRESS_EN.
module debounce_chan
  import button_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = 20,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_debounce,
  output logic btn_busy,
  output logic btn_long
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_r, sync2_r;
  deb_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             deb_r, deb_s;
  logic             busy_r, busy_s;

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Next-state and counter logic; any disagreement with the candidate level
  // drops back to the current stable state and discards the count.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      STABLE_LO: begin
        if (sync2_r) begin
          state_s = CHK_HI;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s = {CNT_W{1'b0}};
        end
      end
      CHK_HI: begin
        if (!sync2_r) begin
          state_s = STABLE_LO;
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r >= CNT_LAST) begin
          state_s = STABLE_HI;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sync2_r) begin
          state_s = CHK_LO;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s = {CNT_W{1'b0}};
        end
      end
      CHK_LO: begin
        if (sync2_r) begin
          state_s = STABLE_HI;
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r >= CNT_LAST) begin
          state_s = STABLE_LO;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = STABLE_LO;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
    deb_s  = (state_s == STABLE_HI) || (state_s == CHK_LO);
    busy_s = (state_s == CHK_HI) || (state_s == CHK_LO);
  end

  // State, counter and registered level/busy outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= STABLE_LO;
      cnt_r   <= {CNT_W{1'b0}};
      deb_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      deb_r   <= deb_s;
      busy_r  <= busy_s;
    end
  end

  assign btn_debounce = deb_r;
  assign btn_busy     = busy_r;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
  localparam int HOLD_W = min_cnt_w(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold_r;
  logic              long_r;

  // Hold counter parks one past the pulse point so the pulse fires once per press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_r <= {HOLD_W{1'b0}};
      long_r <= 1'b0;
    end else begin
      long_r <= (state_r == STABLE_HI) && (hold_r == HOLD_LAST);
      if (state_r != STABLE_HI) begin
        hold_r <= {HOLD_W{1'b0}};
      end else if (hold_r != HOLD_SAT) begin
        hold_r <= hold_r + HOLD_ONE;
      end else begin
        hold_r <= hold_r;
      end
    end
  end

  assign btn_long = long_r;
`else
  assign btn_long = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer; N_BTN independent debounce_chan instances.
// Optional long-press pulse enabled by defining BUTTON_DEBOUNCE_LONGPRESS_EN.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int N_BTN         = 5,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = 20,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_debounce,
  output logic [N_BTN-1:0] btn_busy,
  output logic [N_BTN-1:0] btn_long
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W),
      .LONG_CYCLES  (LONG_CYCLES)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw[i]),
      .btn_debounce(btn_debounce[i]),
      .btn_busy    (btn_busy[i]),
      .btn_long    (btn_long[i])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: stimulus queues expected output edges,
// a monitor pops them whenever btn_debounce changes.
module tb_button_debounce;

  localparam int N_BTN  = 2;
  localparam int STABLE = 8;
  localparam int LONG   = 20;
  localparam int LAT    = STABLE + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N_BTN-1:0] btn_raw = 2'b00;
  logic [N_BTN-1:0] btn_debounce, btn_busy, btn_long;

  button_debounce #(
    .N_BTN(N_BTN), .STABLE_CYCLES(STABLE), .CNT_W(4), .LONG_CYCLES(LONG)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_debounce(btn_debounce), .btn_busy(btn_busy), .btn_long(btn_long)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    int   ch;
    logic val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   long_seen = 0;
  int   long_cyc  = -1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int c, input int ch, input logic v);
    exp_t e;
    e.cyc = c;
    e.ch  = ch;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every change of btn_debounce must match the head of the queue.
  initial begin
    logic [N_BTN-1:0] prev_deb;
    exp_t e;
    prev_deb = 2'b00;
    forever begin
      @(negedge clk);
      if (btn_long != 2'b00) begin
        long_seen++;
        long_cyc = cyc;
      end
      for (int ch = 0; ch < N_BTN; ch++) begin
        if (btn_debounce[ch] !== prev_deb[ch]) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_edge: ch%0d went to %0b at cycle %0d, none expected",
                     ch, btn_debounce[ch], cyc);
          end else begin
            e = exp_q.pop_front();
            check("edge_chan", ch, e.ch);
            check("edge_cycle", cyc, e.cyc);
            check("edge_value", int'(btn_debounce[ch]), int'(e.val));
          end
        end
      end
      prev_deb = btn_debounce;
    end
  end

  // Stimulus: inputs change on falling edges; cyc then equals the count of
  // rising edges so far, and the next rising edge is the first sampling edge.
  initial begin
    int t;
    int exp_long;

    // Reset with both buttons already held.
    rst = 1'b0;
    btn_raw = 2'b11;
    tick(3);
    check("reset_debounce", int'(btn_debounce), 0);
    check("reset_busy", int'(btn_busy), 0);
    check("reset_long", int'(btn_long), 0);
    rst = 1'b1;
    t = cyc;
    push_exp(t + LAT, 0, 1'b1);
    push_exp(t + LAT, 1, 1'b1);
    tick(5);
    check("rst_release_busy", int'(btn_busy), 3);
    tick(7);
    check("rst_release_busy_done", int'(btn_busy), 0);
    btn_raw = 2'b00;
    t = cyc;
    push_exp(t + LAT, 0, 1'b0);
    push_exp(t + LAT, 1, 1'b0);
    tick(14);

    // Clean press and release on channel 0.
    btn_raw[0] = 1'b1;
    t = cyc;
    push_exp(t + LAT, 0, 1'b1);
    tick(5);
    check("press_busy", int'(btn_busy), 1);
    tick(9);
    check("press_level", int'(btn_debounce), 1);
    btn_raw[0] = 1'b0;
    t = cyc;
    push_exp(t + LAT, 0, 1'b0);
    tick(5);
    check("release_busy", int'(btn_busy), 1);
    tick(9);
    check("release_level", int'(btn_debounce), 0);

    // Bounce: high 5, low 1, then steady high.
    btn_raw[0] = 1'b1;
    tick(5);
    btn_raw[0] = 1'b0;
    tick(1);
    btn_raw[0] = 1'b1;
    t = cyc;
    push_exp(t + LAT, 0, 1'b1);
    tick(14);
    btn_raw[0] = 1'b0;
    push_exp(cyc + LAT, 0, 1'b0);
    tick(14);

    // Glitch seen by the FSM exactly on the would-be completion edge.
    btn_raw[0] = 1'b1;
    tick(7);
    btn_raw[0] = 1'b0;
    tick(1);
    btn_raw[0] = 1'b1;
    t = cyc;
    push_exp(t + LAT, 0, 1'b1);
    tick(14);
    btn_raw[0] = 1'b0;
    push_exp(cyc + LAT, 0, 1'b0);
    tick(14);

    // Independent channels, staggered by 3 cycles.
    btn_raw[0] = 1'b1;
    t = cyc;
    push_exp(t + LAT, 0, 1'b1);
    tick(3);
    btn_raw[1] = 1'b1;
    push_exp(t + 3 + LAT, 1, 1'b1);
    tick(14);
    btn_raw = 2'b00;
    t = cyc;
    push_exp(t + LAT, 0, 1'b0);
    push_exp(t + LAT, 1, 1'b0);
    tick(14);

    // Reset pulse in the middle of a qualification.
    btn_raw[0] = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(1);
    check("midrst_debounce", int'(btn_debounce), 0);
    check("midrst_busy", int'(btn_busy), 0);
    rst = 1'b1;
    t = cyc;
    push_exp(t + LAT, 0, 1'b1);
    tick(14);
    btn_raw[0] = 1'b0;
    push_exp(cyc + LAT, 0, 1'b0);
    tick(14);

    // Long hold: one long-press pulse 20 cycles after the rise, if built.
    long_seen = 0;
    btn_raw[0] = 1'b1;
    t = cyc;
    push_exp(t + LAT, 0, 1'b1);
    tick(45);
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    exp_long = 1;
    check("long_cycle", long_cyc, t + LAT + LONG);
`else
    exp_long = 0;
`endif
    check("long_count", long_seen, exp_long);
    btn_raw[0] = 1'b0;
    push_exp(cyc + LAT, 0, 1'b0);
    tick(14);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
